stage_operator_writeback: RTL and testbench

- Sits at the tail of the operator pipeline, after the waveform/envelope stages.
- Receives one finished operator output per cycle, tagged with its VoiceOperatorID and algorithm word.
- Drives the operator-writeback bus (ID, value, enable) that the phase modulator consumes for later modulation.
- Sums all carrier outputs of one full frame (every voice, every operator) into one saturated 16-bit output sample, offered downstream on a valid/ready handshake.

---
 rtl/stage_operator_writeback_if.sv | 40 ++++
 rtl/stage_operator_writeback.sv | 162 ++++++++++++++++
 tb/tb_stage_operator_writeback.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_operator_writeback_if.sv
// rtl/stage_operator_writeback_if.sv - operator writeback / frame sample bus bundle
interface stage_operator_writeback_if #(
  parameter int ID_WIDTH  = 8,
  parameter int ALG_WIDTH = 8
);
  // Operator beat from the envelope stage
  logic                 i_Valid;
  logic [ID_WIDTH-1:0]  i_VoiceOperator;
  logic [ALG_WIDTH-1:0] i_AlgorithmWord;
  logic signed [15:0]   i_OperatorOutput;

  // Writeback bus towards the phase modulator
  logic                 o_OperatorWritebackEnable;
  logic [ID_WIDTH-1:0]  o_OperatorWritebackID;
  logic signed [15:0]   o_OperatorWritebackValue;

  // Frame sample handshake
  logic                 o_SampleValid;
  logic                 i_SampleReady;
  logic signed [15:0]   o_Sample;

  // Sticky status
  logic                 o_SequenceError;
  logic                 o_Overrun;
  logic                 i_ClearErrors;

  modport slave (
    input  i_Valid, i_VoiceOperator, i_AlgorithmWord, i_OperatorOutput,
    output o_OperatorWritebackEnable, o_OperatorWritebackID, o_OperatorWritebackValue,
    output o_SampleValid, input i_SampleReady, output o_Sample,
    output o_SequenceError, output o_Overrun, input i_ClearErrors
  );

  modport master (
    output i_Valid, i_VoiceOperator, i_AlgorithmWord, i_OperatorOutput,
    input  o_OperatorWritebackEnable, o_OperatorWritebackID, o_OperatorWritebackValue,
    input  o_SampleValid, output i_SampleReady, input o_Sample,
    input  o_SequenceError, input o_Overrun, output i_ClearErrors
  );
endinterface

// File: rtl/stage_operator_writeback.sv
// rtl/stage_operator_writeback.sv - operator writeback and saturated frame carrier summation
module stage_operator_writeback #(
  parameter int NUM_VOICES   = 32,
  parameter int CARRIER_BIT  = 7,
  parameter int OUTPUT_SHIFT = 4,
  parameter int ACC_WIDTH    = 24
) (
  input logic                   i_Clock,
  input logic                   i_Reset_n,
  stage_operator_writeback_if.slave stageBus
);
  localparam int ID_WIDTH = $clog2(NUM_VOICES) + 3;
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_VOICES * 8 - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(32768);

  typedef enum logic {SYNC, ACCUM} state_t;

  state_t state, stateNext;
  logic signed [ACC_WIDTH-1:0] acc, accNext;
  logic [ID_WIDTH-1:0] expectedId, expectedIdNext;
  logic frameEnd, sequenceEvent, overrunEvent;

  logic signed [ACC_WIDTH-1:0] contribution, frameTotal, shifted;
  logic signed [15:0] satSample;

  logic wbEnable;
  logic [ID_WIDTH-1:0] wbId;
  logic signed [15:0] wbValue;
  logic sampleValid, sequenceError, overrun;
  logic signed [15:0] sample;

  logic isFirstId;
  assign isFirstId = (stageBus.i_VoiceOperator == '0);

  // Only carriers feed the mix; modulators contribute nothing.
  assign contribution = stageBus.i_AlgorithmWord[CARRIER_BIT]
                      ? {{(ACC_WIDTH-16){stageBus.i_OperatorOutput[15]}}, stageBus.i_OperatorOutput}
                      : '0;
  assign frameTotal = acc + contribution;
  assign shifted    = frameTotal >>> OUTPUT_SHIFT;

  // Clamp the scaled frame sum into the 16-bit sample range.
  always_comb begin
    satSample = shifted[15:0];
    if (shifted > SAT_MAX) begin
      satSample = 16'sh7FFF;
    end else if (shifted < SAT_MIN) begin
      satSample = -16'sh8000;
    end
  end

  // Frame tracking: next state, accumulator and expected ID.
  always_comb begin
    stateNext      = state;
    accNext        = acc;
    expectedIdNext = expectedId;
    frameEnd       = 1'b0;
    sequenceEvent  = 1'b0;
    if (stageBus.i_Valid) begin
      case (state)
        SYNC: begin
          if (isFirstId) begin
            stateNext      = ACCUM;
            accNext        = contribution;
            expectedIdNext = ID_WIDTH'(1);
          end
        end
        ACCUM: begin
          if (stageBus.i_VoiceOperator == expectedId) begin
            if (stageBus.i_VoiceOperator == LAST_ID) begin
              frameEnd       = 1'b1;
              accNext        = '0;
              expectedIdNext = '0;
            end else begin
              accNext        = frameTotal;
              expectedIdNext = expectedId + ID_WIDTH'(1);
            end
          end else begin
            // A stray ID 0 is taken as the start of a fresh frame.
            sequenceEvent = 1'b1;
            if (isFirstId) begin
              accNext        = contribution;
              expectedIdNext = ID_WIDTH'(1);
            end else begin
              stateNext      = SYNC;
              accNext        = '0;
              expectedIdNext = '0;
            end
          end
        end
        default: begin
          stateNext      = SYNC;
          accNext        = '0;
          expectedIdNext = '0;
        end
      endcase
    end
  end

  assign overrunEvent = frameEnd && sampleValid && !stageBus.i_SampleReady;

  // Frame state registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= SYNC;
      acc        <= '0;
      expectedId <= '0;
    end else begin
      state      <= stateNext;
      acc        <= accNext;
      expectedId <= expectedIdNext;
    end
  end

  // Writeback mirrors every beat one cycle later; ID/value hold when idle.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wbEnable <= 1'b0;
      wbId     <= '0;
      wbValue  <= '0;
    end else begin
      wbEnable <= stageBus.i_Valid;
      if (stageBus.i_Valid) begin
        wbId    <= stageBus.i_VoiceOperator;
        wbValue <= stageBus.i_OperatorOutput;
      end
    end
  end

  // Output sample holding register with valid/ready handshake.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sampleValid <= 1'b0;
      sample      <= '0;
    end else if (frameEnd && (!sampleValid || stageBus.i_SampleReady)) begin
      sampleValid <= 1'b1;
      sample      <= satSample;
    end else if (sampleValid && stageBus.i_SampleReady) begin
      sampleValid <= 1'b0;
    end
  end

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sequenceError <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sequenceError <= sequenceEvent || (sequenceError && !stageBus.i_ClearErrors);
      overrun       <= overrunEvent  || (overrun && !stageBus.i_ClearErrors);
    end
  end

  assign stageBus.o_OperatorWritebackEnable = wbEnable;
  assign stageBus.o_OperatorWritebackID     = wbId;
  assign stageBus.o_OperatorWritebackValue  = wbValue;
  assign stageBus.o_SampleValid             = sampleValid;
  assign stageBus.o_Sample                  = sample;
  assign stageBus.o_SequenceError           = sequenceError;
  assign stageBus.o_Overrun                 = overrun;
endmodule

// File: tb/tb_stage_operator_writeback.sv
// tb/tb_stage_operator_writeback.sv - bench for stage_operator_writeback
module tb_stage_operator_writeback;
  localparam int FRAME_LEN = 16;

  logic clk;
  logic rstN;

  stage_operator_writeback_if #(.ID_WIDTH(4), .ALG_WIDTH(8)) busA();
  stage_operator_writeback_if #(.ID_WIDTH(4), .ALG_WIDTH(8)) busB();

  stage_operator_writeback #(.NUM_VOICES(2), .CARRIER_BIT(7), .OUTPUT_SHIFT(4), .ACC_WIDTH(24))
    dutA (.i_Clock(clk), .i_Reset_n(rstN), .stageBus(busA.slave));
  stage_operator_writeback #(.NUM_VOICES(2), .CARRIER_BIT(7), .OUTPUT_SHIFT(0), .ACC_WIDTH(24))
    dutB (.i_Clock(clk), .i_Reset_n(rstN), .stageBus(busB.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Driven stimulus
  bit vValid, vReady, vClear;
  int vId, vVal;
  logic [7:0] vAlg;

  // Reference model: frame kept as a list of contributions
  bit inFrame;
  int frameQ[$];
  bit mEn, mSeq;
  int mId, mVal;
  bit mValid[2];
  bit mOver[2];
  int mSample[2];
  int shiftOf[2] = '{4, 0};

  typedef struct {
    bit valid; int id; int val; bit carrier; bit ready;
    bit expEn; int expId; int expVal; bit expSv; int expSample;
  } vec_t;
  vec_t vecs[FRAME_LEN+1];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int satShift(input int total, input int sh);
    int s;
    s = total >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic applyInputs();
    busA.i_Valid = vValid; busB.i_Valid = vValid;
    busA.i_VoiceOperator = vId[3:0]; busB.i_VoiceOperator = vId[3:0];
    busA.i_AlgorithmWord = vAlg; busB.i_AlgorithmWord = vAlg;
    busA.i_OperatorOutput = vVal[15:0]; busB.i_OperatorOutput = vVal[15:0];
    busA.i_SampleReady = vReady; busB.i_SampleReady = vReady;
    busA.i_ClearErrors = vClear; busB.i_ClearErrors = vClear;
  endtask

  task automatic modelReset();
    inFrame = 0; frameQ.delete();
    mEn = 0; mSeq = 0; mId = 0; mVal = 0;
    for (int k = 0; k < 2; k++) begin
      mValid[k] = 0; mOver[k] = 0; mSample[k] = 0;
    end
  endtask

  task automatic modelStep();
    bit fe, se;
    int total, contrib;
    fe = 0; se = 0; total = 0;
    contrib = vAlg[7] ? vVal : 0;
    if (vValid) begin
      if (!inFrame) begin
        if (vId == 0) begin
          inFrame = 1; frameQ.delete(); frameQ.push_back(contrib);
        end
      end else if (vId == frameQ.size()) begin
        frameQ.push_back(contrib);
        if (frameQ.size() == FRAME_LEN) begin
          fe = 1;
          foreach (frameQ[i]) total += frameQ[i];
          frameQ.delete();
        end
      end else begin
        se = 1;
        frameQ.delete();
        if (vId == 0) frameQ.push_back(contrib);
        else inFrame = 0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      bit ov;
      ov = 0;
      if (fe) begin
        if (!mValid[k] || vReady) begin
          mSample[k] = satShift(total, shiftOf[k]);
          mValid[k] = 1;
        end else begin
          ov = 1;
        end
      end else if (mValid[k] && vReady) begin
        mValid[k] = 0;
      end
      mOver[k] = ov || (mOver[k] && !vClear);
    end
    mSeq = se || (mSeq && !vClear);
    mEn = vValid;
    if (vValid) begin
      mId = vId; mVal = vVal;
    end
  endtask

  task automatic compareModel();
    check("A.wbEn", int'(busA.o_OperatorWritebackEnable), int'(mEn));
    check("A.wbId", int'(busA.o_OperatorWritebackID), mId);
    check("A.wbVal", int'(busA.o_OperatorWritebackValue), mVal);
    check("A.sampleValid", int'(busA.o_SampleValid), int'(mValid[0]));
    check("A.sample", int'(busA.o_Sample), mSample[0]);
    check("A.seqErr", int'(busA.o_SequenceError), int'(mSeq));
    check("A.overrun", int'(busA.o_Overrun), int'(mOver[0]));
    check("B.wbVal", int'(busB.o_OperatorWritebackValue), mVal);
    check("B.sampleValid", int'(busB.o_SampleValid), int'(mValid[1]));
    check("B.sample", int'(busB.o_Sample), mSample[1]);
    check("B.seqErr", int'(busB.o_SequenceError), int'(mSeq));
    check("B.overrun", int'(busB.o_Overrun), int'(mOver[1]));
  endtask

  // One clock: drive, let the edge happen, advance model, compare at negedge.
  task automatic tick();
    applyInputs();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareModel();
  endtask

  task automatic idle();
    vValid = 0; vClear = 0;
    tick();
  endtask

  task automatic beat(input int id, input int val, input bit carrier);
    vValid = 1; vId = id; vVal = val;
    vAlg = {carrier, 7'($urandom)};
    tick();
  endtask

  task automatic frame(input int val, input bit allCarrier, input bit readyAtEnd);
    bit keep;
    keep = vReady;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == FRAME_LEN - 1) vReady = readyAtEnd;
      beat(i, val, allCarrier || (i % 8 == 0));
    end
    vReady = keep;
    vValid = 0;
  endtask

  initial begin
    int nextId;
    rstN = 1'b0;
    vValid = 0; vReady = 1; vClear = 0; vId = 0; vVal = 0; vAlg = 0;
    applyInputs();
    modelReset();
    repeat (2) @(negedge clk);
    check("reset.wbEn", int'(busA.o_OperatorWritebackEnable), 0);
    check("reset.sampleValid", int'(busA.o_SampleValid), 0);
    check("reset.sample", int'(busA.o_Sample), 0);
    check("reset.seqErr", int'(busA.o_SequenceError), 0);
    check("reset.overrun", int'(busA.o_Overrun), 0);
    rstN = 1'b1;

    // Directed table: one frame, op0 carriers at 1000
    for (int i = 0; i < FRAME_LEN; i++) begin
      vecs[i] = '{valid: 1, id: i, val: 1000, carrier: (i % 8 == 0), ready: 1,
                  expEn: 1, expId: i, expVal: 1000,
                  expSv: (i == FRAME_LEN - 1), expSample: (i == FRAME_LEN - 1) ? 125 : 0};
    end
    vecs[FRAME_LEN] = '{valid: 0, id: 0, val: 0, carrier: 0, ready: 1,
                        expEn: 0, expId: 15, expVal: 1000, expSv: 0, expSample: 125};
    for (int i = 0; i <= FRAME_LEN; i++) begin
      vValid = vecs[i].valid; vId = vecs[i].id; vVal = vecs[i].val;
      vAlg = {vecs[i].carrier, 7'($urandom)}; vReady = vecs[i].ready; vClear = 0;
      tick();
      check("vec.wbEn", int'(busA.o_OperatorWritebackEnable), int'(vecs[i].expEn));
      check("vec.wbId", int'(busA.o_OperatorWritebackID), vecs[i].expId);
      check("vec.wbVal", int'(busA.o_OperatorWritebackValue), vecs[i].expVal);
      check("vec.sampleValid", int'(busA.o_SampleValid), int'(vecs[i].expSv));
      check("vec.sample", int'(busA.o_Sample), vecs[i].expSample);
    end

    // Saturation at both rails on the unshifted instance
    frame(32767, 1, 1);
    check("satHi.B", int'(busB.o_Sample), 32767);
    check("satHi.A", int'(busA.o_Sample), 32767);
    frame(-32768, 1, 1);
    check("satLo.B", int'(busB.o_Sample), -32768);
    idle();

    // Sequence error, resync, then clear
    beat(0, 100, 1); beat(1, 100, 1); beat(2, 100, 1); beat(5, 100, 1);
    check("seq.flag", int'(busA.o_SequenceError), 1);
    beat(6, 100, 1);
    frame(16, 1, 1);
    check("seq.resyncSample", int'(busA.o_Sample), 16);
    vClear = 1; vValid = 0; tick(); vClear = 0;
    check("seq.cleared", int'(busA.o_SequenceError), 0);

    // Overrun: second frame end with consumer stalled
    vReady = 0;
    frame(1000, 0, 0);
    frame(2000, 0, 0);
    check("ovr.heldSample", int'(busA.o_Sample), 125);
    check("ovr.flag", int'(busA.o_Overrun), 1);
    vReady = 1; vClear = 1; vValid = 0; tick(); vClear = 0;
    check("ovr.cleared", int'(busA.o_Overrun), 0);
    vReady = 0;
    frame(1000, 0, 0);
    frame(2000, 0, 1);
    check("ovr.newSample", int'(busA.o_Sample), 250);
    check("ovr.validKept", int'(busA.o_SampleValid), 1);
    check("ovr.noFlag", int'(busA.o_Overrun), 0);
    vReady = 1;
    idle();

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 9; i++) beat(i, 1000, (i % 8 == 0));
    vValid = 1; vId = 9; vVal = 1000; vAlg = 8'h00;
    applyInputs();
    #2 rstN = 1'b0;
    #1;
    modelReset();
    check("arst.wbEn", int'(busA.o_OperatorWritebackEnable), 0);
    check("arst.wbId", int'(busA.o_OperatorWritebackID), 0);
    check("arst.wbVal", int'(busA.o_OperatorWritebackValue), 0);
    check("arst.sampleValid", int'(busA.o_SampleValid), 0);
    check("arst.sample", int'(busA.o_Sample), 0);
    check("arst.seqErr", int'(busA.o_SequenceError), 0);
    check("arst.overrun", int'(busA.o_Overrun), 0);
    @(negedge clk);
    rstN = 1'b1;
    vValid = 0;
    for (int i = 3; i < FRAME_LEN; i++) beat(i, 1000, 1);
    check("arst.ignoredNoErr", int'(busA.o_SequenceError), 0);
    check("arst.ignoredNoSample", int'(busA.o_SampleValid), 0);
    frame(1000, 0, 1);
    check("arst.frameSample", int'(busA.o_Sample), 125);

    // Randomised traffic against the model
    nextId = 0;
    for (int c = 0; c < 3000; c++) begin
      vValid = ($urandom_range(0, 99) < 80);
      if (vValid) begin
        if ($urandom_range(0, 99) < 4) vId = $urandom_range(0, FRAME_LEN - 1);
        else vId = nextId;
        nextId = (vId + 1) % FRAME_LEN;
      end
      vVal = $urandom_range(0, 65535) - 32768;
      vAlg = 8'($urandom);
      vReady = $urandom_range(0, 1);
      vClear = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
